// File: rtl/apb_pkg.sv
// Shared definitions for the APB master bridge: FSM state encoding and default widths.
package apb_pkg;

    localparam int unsigned APB_ADDR_WIDTH     = 8;
    localparam int unsigned APB_DATA_WIDTH     = 32;
    localparam int unsigned APB_TIMEOUT_CYCLES = 16;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        RESP
    } apb_state_e;

endpackage

// File: rtl/apb_master_bridge.sv
// Single-command APB master: valid/ready command in, valid/ready response out,
// with a PREADY wait timeout that completes the transfer as an error.
module apb_master_bridge
    import apb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = APB_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH     = APB_DATA_WIDTH,
    parameter int unsigned TIMEOUT_CYCLES = APB_TIMEOUT_CYCLES
) (
    input  logic                  PCLK,
    input  logic                  PRESETn,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  PSEL,
    output logic                  PENABLE,
    output logic                  PWRITE,
    output logic [ADDR_WIDTH-1:0] PADDR,
    output logic [DATA_WIDTH-1:0] PWDATA,
    input  logic [DATA_WIDTH-1:0] PRDATA,
    input  logic                  PREADY,
    input  logic                  PSLVERR
);

    localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT_CYCLES);

    apb_state_e state;
    apb_state_e state_next;
    logic [7:0] wait_cnt;
    logic [7:0] wait_cnt_inc;
    logic       accept;
    logic       complete;
    logic       timeout;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next   = state;
        req_ready    = 1'b0;
        rsp_valid    = 1'b0;
        PSEL         = 1'b0;
        PENABLE      = 1'b0;
        accept       = 1'b0;
        complete     = 1'b0;
        timeout      = 1'b0;
        wait_cnt_inc = wait_cnt + 8'd1;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    accept     = 1'b1;
                    state_next = SETUP;
                end
            end
            SETUP: begin
                PSEL       = 1'b1;
                state_next = ACCESS;
            end
            ACCESS: begin
                PSEL    = 1'b1;
                PENABLE = 1'b1;
                // PREADY wins over a timeout landing in the same cycle
                if (PREADY) begin
                    complete   = 1'b1;
                    state_next = RESP;
                end else if (wait_cnt_inc == TIMEOUT_LIMIT) begin
                    timeout    = 1'b1;
                    state_next = RESP;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            wait_cnt  <= '0;
            PWRITE    <= 1'b0;
            PADDR     <= '0;
            PWDATA    <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            if (accept) begin
                PWRITE   <= req_write;
                PADDR    <= req_addr;
                PWDATA   <= req_wdata;
                wait_cnt <= '0;
            end
            if (state == ACCESS && !PREADY) begin
                wait_cnt <= wait_cnt_inc;
            end
            if (complete) begin
                rsp_rdata <= (PWRITE || PSLVERR) ? '0 : PRDATA;
                rsp_err   <= PSLVERR;
            end
            if (timeout) begin
                rsp_rdata <= '0;
                rsp_err   <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed bench for apb_master_bridge: APB slave model, a transaction-level reference
// model checked every cycle, and literal expectations pinned on each response.
module tb_apb_master_bridge;

    localparam int TB_TIMEOUT = 16;

    logic        PCLK;
    logic        PRESETn;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [7:0]  req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [7:0]  PADDR;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;

    apb_master_bridge #(
        .ADDR_WIDTH    (8),
        .DATA_WIDTH    (32),
        .TIMEOUT_CYCLES(TB_TIMEOUT)
    ) dut (
        .PCLK     (PCLK),
        .PRESETn  (PRESETn),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_write(req_write),
        .req_addr (req_addr),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata),
        .rsp_err  (rsp_err),
        .PSEL     (PSEL),
        .PENABLE  (PENABLE),
        .PWRITE   (PWRITE),
        .PADDR    (PADDR),
        .PWDATA   (PWDATA),
        .PRDATA   (PRDATA),
        .PREADY   (PREADY),
        .PSLVERR  (PSLVERR)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    always @(posedge PCLK) cyc <= cyc + 1;

    // Slave configuration (driver-owned)
    int          cfg_waits = 0;
    logic        cfg_err   = 1'b0;
    logic        noise     = 1'b0;
    logic        pin_on    = 1'b0;
    int          pin_lat   = 0;
    logic [31:0] pin_rdata = '0;
    logic        pin_err   = 1'b0;

    // APB slave: cfg_waits low ACCESS cycles then PREADY; noise drives junk outside ACCESS
    logic [31:0] slave_mem [256] = '{default: '0};
    int          slave_cnt = 0;

    always_comb begin
        PREADY  = noise;
        PSLVERR = noise;
        PRDATA  = noise ? '1 : '0;
        if (PSEL && PENABLE) begin
            PREADY  = (slave_cnt >= cfg_waits);
            PSLVERR = cfg_err;
            PRDATA  = slave_mem[PADDR];
        end
    end

    always @(posedge PCLK) begin
        if (PSEL && PENABLE && !PREADY) slave_cnt <= slave_cnt + 1;
        else slave_cnt <= 0;
        if (PSEL && PENABLE && PREADY && PWRITE && !cfg_err) slave_mem[PADDR] <= PWDATA;
    end

    // Reference model state (compare-process-owned)
    logic [31:0] ref_mem [256] = '{default: '0};
    logic        busy = 1'b0;
    int          a_cyc = 0;
    int          resp_start = 0;
    int          acc_cycles = 0;
    int          resp_low = 0;
    logic        cmd_write = 1'b0;
    logic [7:0]  cmd_addr = '0;
    logic [31:0] cmd_wdata = '0;
    logic [31:0] exp_rdata = '0;
    logic        exp_err = 1'b0;
    logic        pin_act = 1'b0;
    int          pin_lat_c = 0;
    logic [31:0] pin_rdata_c = '0;
    logic        pin_err_c = 1'b0;
    logic        e_psel, e_pen, e_rv;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endfunction

    always @(negedge PCLK) begin
        if (!PRESETn) begin
            busy = 1'b0;
            chk("rst_psel", 32'(PSEL), 32'd0);
            chk("rst_penable", 32'(PENABLE), 32'd0);
            chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
            chk("rst_req_ready", 32'(req_ready), 32'd1);
            chk("rst_pwrite", 32'(PWRITE), 32'd0);
            chk("rst_paddr", 32'(PADDR), 32'd0);
            chk("rst_pwdata", PWDATA, 32'd0);
            chk("rst_rsp_rdata", rsp_rdata, 32'd0);
            chk("rst_rsp_err", 32'(rsp_err), 32'd0);
        end else begin
            e_psel = 1'b0;
            e_pen  = 1'b0;
            e_rv   = 1'b0;
            if (busy) begin
                if (cyc == a_cyc + 1) e_psel = 1'b1;
                else if (cyc < resp_start) begin
                    e_psel = 1'b1;
                    e_pen  = 1'b1;
                end else e_rv = 1'b1;
            end
            chk("req_ready", 32'(req_ready), 32'(!busy));
            chk("psel", 32'(PSEL), 32'(e_psel));
            chk("penable", 32'(PENABLE), 32'(e_pen));
            chk("rsp_valid", 32'(rsp_valid), 32'(e_rv));
            if (e_psel) begin
                chk("paddr", 32'(PADDR), 32'(cmd_addr));
                chk("pwrite", 32'(PWRITE), 32'(cmd_write));
                chk("pwdata", PWDATA, cmd_wdata);
            end
            if (e_rv) begin
                chk("rsp_rdata", rsp_rdata, exp_rdata);
                chk("rsp_err", 32'(rsp_err), 32'(exp_err));
            end
            // Literal pins: rsp_valid first seen in cycle pin_lat counting the accept cycle as 1
            if (busy && pin_act) begin
                if (cyc == a_cyc + pin_lat_c - 2) chk("pin_rsp_not_yet", 32'(rsp_valid), 32'd0);
                if (cyc == a_cyc + pin_lat_c - 1) begin
                    chk("pin_rsp_valid", 32'(rsp_valid), 32'd1);
                    chk("pin_rsp_rdata", rsp_rdata, pin_rdata_c);
                    chk("pin_rsp_err", 32'(rsp_err), 32'(pin_err_c));
                end
            end
            if (e_rv && !rsp_ready) resp_low++;
            if (busy && e_rv && rsp_ready) begin
                busy = 1'b0;
            end else if (!busy && req_valid) begin
                busy       = 1'b1;
                a_cyc      = cyc;
                cmd_write  = req_write;
                cmd_addr   = req_addr;
                cmd_wdata  = req_wdata;
                acc_cycles = (cfg_waits < TB_TIMEOUT) ? cfg_waits + 1 : TB_TIMEOUT;
                resp_start = a_cyc + 2 + acc_cycles;
                resp_low   = 0;
                if (cfg_waits >= TB_TIMEOUT || cfg_err) begin
                    exp_err   = 1'b1;
                    exp_rdata = '0;
                end else begin
                    exp_err = 1'b0;
                    if (req_write) begin
                        exp_rdata          = '0;
                        ref_mem[req_addr] = req_wdata;
                    end else begin
                        exp_rdata = ref_mem[req_addr];
                    end
                end
                pin_act     = pin_on;
                pin_lat_c   = pin_lat;
                pin_rdata_c = pin_rdata;
                pin_err_c   = pin_err;
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 300) begin
            @(posedge PCLK); #2;
            n++;
        end
        if (busy) begin
            $display("FAIL idle_wait: transfer outstanding after %0d cycles", n);
            $fatal(1, "bench stalled");
        end
    endtask

    task automatic issue(input logic wr, input logic [7:0] addr, input logic [31:0] wd,
                         input int waits, input logic err, input int hold,
                         input int lat, input logic [31:0] prd, input logic perr);
        @(posedge PCLK); #2;
        cfg_waits = waits;
        cfg_err   = err;
        pin_on    = (lat > 0);
        pin_lat   = lat;
        pin_rdata = prd;
        pin_err   = perr;
        req_write = wr;
        req_addr  = addr;
        req_wdata = wd;
        req_valid = 1'b1;
        rsp_ready = (hold == 0);
        @(posedge PCLK); #2;
        if (hold == 0) begin
            req_valid = 1'b0;
        end else begin
            // keep a different command pending; it must be ignored until IDLE
            req_addr  = addr ^ 8'hFF;
            req_wdata = ~wd;
            req_write = !wr;
            for (int i = 0; i < 200 && resp_low < hold; i++) begin
                @(posedge PCLK); #2;
            end
            rsp_ready = 1'b1;
            req_valid = 1'b0;
        end
    endtask

    task automatic xfer(input logic wr, input logic [7:0] addr, input logic [31:0] wd,
                        input int waits, input logic err, input int hold,
                        input int lat, input logic [31:0] prd, input logic perr);
        issue(wr, addr, wd, waits, err, hold, lat, prd, perr);
        wait_idle();
    endtask

    initial begin
        PRESETn   = 1'b0;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        rsp_ready = 1'b1;
        repeat (3) @(posedge PCLK);
        #2 PRESETn = 1'b1;

        //   wr    addr   wdata          waits err hold lat rdata          err
        xfer(1'b1, 8'h10, 32'hDEADBEEF,  0,   0,  0,   4,  32'h0,         1'b0);
        xfer(1'b0, 8'h10, 32'h0,         0,   0,  0,   4,  32'hDEADBEEF,  1'b0);
        xfer(1'b1, 8'h20, 32'hCAFEBABE,  0,   0,  0,   4,  32'h0,         1'b0);
        xfer(1'b0, 8'h20, 32'h0,         3,   0,  0,   7,  32'hCAFEBABE,  1'b0);
        xfer(1'b0, 8'h20, 32'h0,         1000, 0, 0,   19, 32'h0,         1'b1);
        xfer(1'b0, 8'h10, 32'h0,         15,  0,  0,   19, 32'hDEADBEEF,  1'b0);
        xfer(1'b1, 8'h30, 32'h12345678,  0,   1,  0,   4,  32'h0,         1'b1);
        xfer(1'b0, 8'h30, 32'h0,         0,   0,  0,   4,  32'h0,         1'b0);
        xfer(1'b0, 8'h10, 32'h0,         0,   1,  0,   4,  32'h0,         1'b1);
        noise = 1'b1;
        xfer(1'b0, 8'h20, 32'h0,         0,   0,  5,   4,  32'hCAFEBABE,  1'b0);
        xfer(1'b1, 8'h40, 32'hA5A5A5A5,  2,   0,  0,   6,  32'h0,         1'b0);
        xfer(1'b0, 8'h40, 32'h0,         0,   0,  0,   4,  32'hA5A5A5A5,  1'b0);
        noise = 1'b0;

        // Reset while the slave stalls in ACCESS; no response may follow
        issue(1'b0, 8'h20, 32'h0, 1000, 0, 0, 0, 32'h0, 1'b0);
        repeat (3) begin
            @(posedge PCLK); #2;
        end
        PRESETn = 1'b0;
        repeat (2) begin
            @(posedge PCLK); #2;
        end
        PRESETn = 1'b1;
        repeat (20) @(posedge PCLK);

        xfer(1'b0, 8'h10, 32'h0,         0,   0,  0,   4,  32'hDEADBEEF,  1'b0);
        repeat (3) @(posedge PCLK);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/apb_master_bridge.md
APB_MASTER_BRIDGE -- requirements
Module: apb_master_bridge

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 8, APB address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, APB data width.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 16, the maximum number of ACCESS cycles with PREADY low before abort; legal range 1..255.
REQ-004 SHALL have port PCLK, input, 1, the single clock; all logic rising-edge.
REQ-005 SHALL have port PRESETn, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port req_valid, input, 1, command valid.
REQ-007 SHALL have port req_ready, output, 1, command accepted this cycle when high together with req_valid.
REQ-008 SHALL have port req_write, input, 1, where 1 is a write and 0 is a read.
REQ-009 SHALL have port req_addr, input, ADDR_WIDTH, command address.
REQ-010 SHALL have port req_wdata, input, DATA_WIDTH, write data.
REQ-011 SHALL have port rsp_valid, output, 1, response valid.
REQ-012 SHALL have port rsp_ready, input, 1, response consumed.
REQ-013 SHALL have port rsp_rdata, output, DATA_WIDTH, read data, which is 0 for writes and errors.
REQ-014 SHALL have port rsp_err, output, 1, set on a slave error or a timeout.
REQ-015 SHALL have APB master ports PSEL, PENABLE, PWRITE (output, 1); PADDR (output, ADDR_WIDTH); PWDATA (output, DATA_WIDTH).
REQ-016 SHALL have APB return ports PRDATA (input, DATA_WIDTH), PREADY (input, 1), PSLVERR (input, 1).

Function
REQ-017 SHALL implement FSM states IDLE, SETUP, ACCESS, RESP.
REQ-018 SHALL drive req_ready=1 only in IDLE, combinationally from state.
REQ-019 SHALL, in IDLE with req_valid=1, latch req_write/req_addr/req_wdata and go to SETUP.
REQ-020 SHALL, in SETUP, drive PSEL=1 and PENABLE=0, then go to ACCESS unconditionally on the next edge.
REQ-021 SHALL, in ACCESS, drive PSEL=1 and PENABLE=1, holding PADDR/PWRITE/PWDATA stable from SETUP through the end of ACCESS.
REQ-022 SHALL, in ACCESS with PREADY=1, capture PRDATA (reads only, else 0) into rsp_rdata and PSLVERR into rsp_err, then go to RESP.
REQ-023 SHALL count ACCESS cycles with PREADY=0 using an 8-bit wait counter cleared on entry to SETUP.
REQ-024 SHALL, when the wait counter reaches TIMEOUT_CYCLES with PREADY still 0, go to RESP with rsp_err=1 and rsp_rdata=0, deasserting PSEL/PENABLE on that edge.
REQ-025 SHALL let PREADY=1 in the same cycle the timeout would fire take priority, completing the transfer normally.
REQ-026 SHALL hold rsp_valid=1 and stable rsp_rdata/rsp_err in RESP until rsp_ready=1, then return to IDLE.
REQ-027 SHALL drive PSEL=0 and PENABLE=0 in IDLE and RESP; PENABLE SHALL never be 1 while PSEL=0.
REQ-028 SHALL give a zero-wait-state transfer exactly 4 cycles from acceptance to IDLE when rsp_ready is held at 1 (accept, SETUP, ACCESS, RESP).
REQ-029 SHALL ignore req_valid outside IDLE; no command queuing.
REQ-030 SHALL ignore PREADY/PSLVERR/PRDATA outside ACCESS.

Reset
REQ-031 SHALL, on PRESETn=0 (asynchronous, any state including mid-ACCESS), force state=IDLE, wait counter=0, PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, rsp_valid=0, rsp_rdata=0, rsp_err=0.
REQ-032 SHALL abandon any in-flight transfer after reset release, with no response issued for it.

Structure
REQ-033 SHALL place the FSM state enum and the default width constants in shared package apb_pkg.
REQ-034 SHALL be a single module with the wait counter inline; no sub-module.

Verification
REQ-035 SHALL verify a zero-wait write (0x10, 0xDEADBEEF) against apb_slave, with the read of 0x10 returning rsp_rdata=0xDEADBEEF and rsp_err=0.
REQ-036 SHALL verify that PREADY held low for 3 ACCESS cycles on a read of 0x20 (PRDATA=0xCAFEBABE) gives rsp_valid 7 cycles after acceptance with the data correct.
REQ-037 SHALL verify that PREADY held low permanently with TIMEOUT_CYCLES=16 gives rsp_err=1 and rsp_rdata=0 after 16 ACCESS cycles, with PSEL dropping.
REQ-038 SHALL verify that PSLVERR=1 with PREADY=1 on a write gives rsp_err=1, and that the next transfer succeeds.
REQ-039 SHALL verify that rsp_ready held low for 5 cycles keeps rsp_valid and the data stable, with req_ready=0 throughout.
REQ-040 SHALL verify that PRESETn asserted mid-ACCESS gives PSEL/PENABLE/rsp_valid=0 immediately, with no response issued after release.
